// File: rtl/alu_nibble_sequencer_if.sv
// Host-side bus of the nibble sequencer: request, operands, status and result.
interface alu_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             cn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;
    logic             cn_out;
    logic             equal;

    // Host side issues requests and observes results.
    modport master (
        output start, a, b, s, m, cn,
        input  busy, done, f, cn_out, equal
    );

    // Sequencer side accepts requests and reports results.
    modport slave (
        input  start, a, b, s, m, cn,
        output busy, done, f, cn_out, equal
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs one external 4-bit 74181 slice over a WIDTH-bit operation, one nibble
// per clock, LSB nibble first, chaining the carry and AND-ing the A=B outputs.
module alu_nibble_sequencer #(
    parameter int WIDTH = 16,
    localparam int NIBBLES = WIDTH / 4
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_nibble_sequencer_if.slave  bus,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_cn,
    input  logic [3:0]             alu_f,
    input  logic                   alu_cn4,
    input  logic                   alu_equal
);
    localparam int IDX_W = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [3:0]         s_reg;
    logic               m_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg;
    logic               eq_acc_reg;
    logic               cn_out_reg;
    logic               equal_reg;
    logic [3:0]         f_nib_reg [NIBBLES];
    logic               accept;
    logic               last_nib;

    assign accept   = (state_reg == IDLE) && bus.start;
    assign last_nib = (idx_reg == IDX_W'(NIBBLES - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start only counts in IDLE; RUN ends on the last nibble.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_nib)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_reg)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, nibble index, carry chain and A=B accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            s_reg      <= '0;
            m_reg      <= 1'b0;
            idx_reg    <= '0;
            carry_reg  <= 1'b0;
            eq_acc_reg <= 1'b0;
            cn_out_reg <= 1'b0;
            equal_reg  <= 1'b0;
        end else if (accept) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            s_reg      <= bus.s;
            m_reg      <= bus.m;
            idx_reg    <= '0;
            carry_reg  <= bus.cn;
            eq_acc_reg <= 1'b1;
        end else if (state_reg == RUN) begin
            carry_reg  <= alu_cn4;
            eq_acc_reg <= eq_acc_reg & alu_equal;
            if (last_nib) begin
                // Back to nibble 0 so the idle slice drive shows the LSB nibble.
                idx_reg    <= '0;
                cn_out_reg <= alu_cn4;
                equal_reg  <= eq_acc_reg & alu_equal;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    // Each result nibble is written only on the RUN edge that addresses it.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_f_nib
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                f_nib_reg[gi] <= '0;
            end else if ((state_reg == RUN) && (idx_reg == IDX_W'(gi))) begin
                f_nib_reg[gi] <= alu_f;
            end
        end
        assign bus.f[gi*4 +: 4] = f_nib_reg[gi];
    end

    assign bus.cn_out = cn_out_reg;
    assign bus.equal  = equal_reg;

    // Slice drive comes straight from the latched registers in every state.
    assign alu_a  = a_reg[4*idx_reg +: 4];
    assign alu_b  = b_reg[4*idx_reg +: 4];
    assign alu_s  = s_reg;
    assign alu_m  = m_reg;
    assign alu_cn = carry_reg;
endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Multi-cycle controller that runs one external 4-bit 74181 ALU slice over a WIDTH-bit operation, one nibble per clock, LSB nibble first.
- Chains the carry through the slice and wire-ANDs the A=B outputs across all nibbles.
- Sits between the SPI config/status register bank and a single alu_74181 instance. This lets wide operands share one slice instead of cascading several.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived nibble count; not overridden.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request pulse; accepted only in IDLE
- a  input  WIDTH  operand A, sampled on accepted start
- b  input  WIDTH  operand B, sampled on accepted start
- s  input  4  74181 function select, sampled on accepted start
- m  input  1  74181 mode (1=logic, 0=arithmetic), sampled on accepted start
- cn  input  1  carry-in to nibble 0 (74181 polarity), sampled on accepted start
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse when results are valid
- f  output  WIDTH  assembled result
- cn_out  output  1  carry out of the last nibble
- equal  output  1  AND of alu_equal over all nibbles
- alu_a  output  4  nibble of A driven to the slice
- alu_b  output  4  nibble of B driven to the slice
- alu_s  output  4  function select to the slice
- alu_m  output  1  mode to the slice
- alu_cn  output  1  carry-in to the slice
- alu_f  input  4  slice result
- alu_cn4  input  1  slice carry out
- alu_equal  input  1  slice A=B output

Behaviour:
- Clock and reset: clk is the only clock. rst asynchronously forces IDLE. All registers clear to 0: f=0, cn_out=0, equal=0, busy=0, done=0, nibble index=0, latched operands/s/m/cn=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On a clk edge with start=1, latch a, b, s, m, cn into internal registers.
  - Set index=0, carry register=cn, equal accumulator=1, then go to RUN.
  - start=0 keeps the FSM in IDLE.
- RUN:
  - busy=1.
  - Slice drive is combinational from registers: alu_a/alu_b = latched nibble[index], alu_s/alu_m = latched s/m, alu_cn = carry register.
  - Each edge: write alu_f into f[4*index+3:4*index], carry register <= alu_cn4, equal accumulator <= accumulator & alu_equal, index++.
  - On the edge that captures index NIBBLES-1: cn_out <= alu_cn4, equal <= accumulator & alu_equal, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Outside RUN, alu_* outputs still reflect the registers (index 0 after reset).
- Latency: start accepted at edge k; last nibble captured at edge k+NIBBLES; done high in the cycle after edge k+NIBBLES (WIDTH=16: 4 cycles of busy, done in the 5th cycle after start).
- Output hold: f, cn_out and equal hold their values until the next accepted start. f is overwritten nibble by nibble during the next RUN; intermediate f values are not valid.
- start in RUN or DONE is ignored and is not queued.
- Input changes on a, b, s, m, cn after acceptance have no effect on the running operation.
- m=1: carry is still chained mechanically, but cn_out has no meaning in logic mode.
- Reset mid-RUN: immediate return to IDLE with all outputs cleared; the partial result is discarded.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, s=4'b1001, m=0, cn=1, start pulse -> busy high for 4 cycles, done in the 5th cycle, f=0x5555, cn_out=1.
- a=0xFFFF, b=0x0001, s=4'b1001, m=0, cn=1 -> f=0x0000, cn_out=0 (carry generated), carry propagated through all 4 nibbles.
- a=b=0x5A5A, s=4'b0110, m=0, cn=1 -> f=0xFFFF, equal=1. Repeat with b=0x5A5B -> equal=0.
- a=0xF0F0, b=0xFF00, s=4'b0110, m=1 -> f=0x0FF0. Hold start high through RUN and DONE -> only one operation performed, and a second starts only on the first IDLE edge.
- Start an add, assert rst for 1 cycle after 2 nibbles -> busy=0, done never pulses, f=0, cn_out=0, equal=0. A subsequent operation completes correctly.
- Change a/b/s mid-RUN -> result matches the operands latched at start. Also check that alu_a/alu_b step through nibbles 0..3 in consecutive cycles.
